// File: rtl/pcfx_mem_pkg.sv
// Shared definitions for the PC-FX memory paths: ROM fetch FSM states,
// the default SDRAM placement of the BIOS image, and address helpers.
package pcfx_mem_pkg;

  localparam logic [24:0] ROM_BASE_DEFAULT = 25'h0000000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DONE = 2'd2
  } fetch_state_e;

  // SDRAM byte address of a 32-bit ROM word; wraps at 25 bits.
  function automatic logic [24:0] rom_word_addr(input logic [24:0] base,
                                                input logic [18:0] word);
    return base + {4'b0000, word, 2'b00};
  endfunction

endpackage

// File: rtl/rom_fetch_sync2.sv
// Two-flop synchronizer for a single toggle/level bit entering the clk_i domain.
// Flops are configuration-initialised only, so toggle state survives reset.
module sync2 (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q = 1'b0;
  logic sync_q = 1'b0;

  always_ff @(posedge clk_i) begin
    meta_q <= d_i;
    sync_q <= meta_q;
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rom_fetch.sv
// CPU-side BIOS/ROM read responder: one-line 32-bit fetch buffer backed by
// SDRAM reads through a toggle request/acknowledge handshake into clk_ram.
module rom_fetch
  import pcfx_mem_pkg::*;
#(
  parameter logic [24:0] ROM_BASE = ROM_BASE_DEFAULT
) (
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic        ce,
  input  logic        inval,
  input  logic        rom_cen,
  input  logic [19:0] rom_a,
  output logic [15:0] rom_do,
  output logic        rom_readyn,
  output logic [24:0] sdram_raddr,
  output logic        sdram_rd_req,
  input  logic        sdram_rd_ack,
  input  logic [31:0] sdram_dout
);

  fetch_state_e state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] line_q, line_d;
  logic [18:0] tag_q, tag_d;
  logic [19:0] addr_q, addr_d;
  logic [24:0] raddr_q, raddr_d;
  logic [15:0] rom_do_q, rom_do_d;
  logic        readyn_q, readyn_d;
  logic        req_tog_q = 1'b0;
  logic        req_tog_d;
  logic        ack_s;
  logic        hit_s;
  logic        outstanding_s;

  sync2 u_ack_sync (
    .clk_i (clk_cpu),
    .d_i   (sdram_rd_ack),
    .q_o   (ack_s)
  );

  assign hit_s         = valid_q && (tag_q == rom_a[19:1]);
  assign outstanding_s = (req_tog_q != ack_s);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    line_d    = line_q;
    tag_d     = tag_q;
    addr_d    = addr_q;
    raddr_d   = raddr_q;
    req_tog_d = req_tog_q;
    rom_do_d  = rom_do_q;
    readyn_d  = readyn_q;

    case (state_q)
      FETCH_IDLE: begin
        if (ce && !rom_cen) begin
          if (hit_s) begin
            addr_d  = rom_a;
            state_d = FETCH_DONE;
          end else if (!outstanding_s) begin
            addr_d    = rom_a;
            raddr_d   = rom_word_addr(ROM_BASE, rom_a[19:1]);
            req_tog_d = ~req_tog_q;
            state_d   = FETCH_WAIT;
          end else begin
            // A fetch abandoned by reset is still in flight; retry later.
            state_d = FETCH_IDLE;
          end
        end else begin
          state_d = FETCH_IDLE;
        end
      end
      FETCH_WAIT: begin
        if (!outstanding_s) begin
          line_d  = sdram_dout;
          tag_d   = addr_q[19:1];
          valid_d = 1'b1;
          state_d = FETCH_DONE;
        end else begin
          state_d = FETCH_WAIT;
        end
      end
      FETCH_DONE: begin
        if (ce) begin
          rom_do_d = addr_q[0] ? line_q[31:16] : line_q[15:0];
          state_d  = FETCH_IDLE;
        end else begin
          state_d = FETCH_DONE;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase

    // The strobe is a registered one-ce-cycle pulse issued from DONE.
    if (ce) begin
      readyn_d = (state_q != FETCH_DONE);
    end else begin
      readyn_d = readyn_q;
    end

    // Download in progress overrides any fill landing on the same edge.
    if (inval) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_d;
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q  <= FETCH_IDLE;
      valid_q  <= 1'b0;
      addr_q   <= 20'h00000;
      raddr_q  <= 25'h0000000;
      rom_do_q <= 16'h0000;
      readyn_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      raddr_q  <= raddr_d;
      rom_do_q <= rom_do_d;
      readyn_q <= readyn_d;
    end
  end

  // Request toggle must survive reset so it stays paired with the ack side.
  always_ff @(posedge clk_cpu) begin
    line_q    <= line_d;
    tag_q     <= tag_d;
    req_tog_q <= req_tog_d;
  end

  assign rom_do       = rom_do_q;
  assign rom_readyn   = readyn_q;
  assign sdram_raddr  = raddr_q;
  assign sdram_rd_req = req_tog_q;

endmodule

// File: tb/tb_rom_fetch.sv
// Scoreboard bench for rom_fetch: directed reads against a toggle-handshake
// SDRAM model running on an unrelated clk_ram.
module tb_rom_fetch;

  localparam logic [24:0] BASE = 25'h0100000;

  logic        clk_cpu = 1'b0;
  logic        clk_ram = 1'b0;
  logic        reset   = 1'b1;
  logic        ce      = 1'b0;
  logic        inval   = 1'b0;
  logic        rom_cen = 1'b1;
  logic [19:0] rom_a   = 20'h00000;
  logic [15:0] rom_do;
  logic        rom_readyn;
  logic [24:0] sdram_raddr;
  logic        sdram_rd_req;
  logic        sdram_rd_ack = 1'b0;
  logic [31:0] sdram_dout   = 32'h00000000;

  rom_fetch #(.ROM_BASE(BASE)) dut (
    .clk_cpu      (clk_cpu),
    .reset        (reset),
    .ce           (ce),
    .inval        (inval),
    .rom_cen      (rom_cen),
    .rom_a        (rom_a),
    .rom_do       (rom_do),
    .rom_readyn   (rom_readyn),
    .sdram_raddr  (sdram_raddr),
    .sdram_rd_req (sdram_rd_req),
    .sdram_rd_ack (sdram_rd_ack),
    .sdram_dout   (sdram_dout)
  );

  always #5 clk_cpu = ~clk_cpu;
  always #4 clk_ram = ~clk_ram;

  // CPU clock enable: every second clk_cpu edge.
  always @(negedge clk_cpu) ce <= ~ce;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          tog_cnt  = 0;
  int          ack_cnt  = 0;
  logic [24:0] last_raddr = 25'h0;
  logic        mon_en   = 1'b0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // SDRAM image contents, hand-assigned per word.
  function automatic logic [31:0] mem_word(input logic [24:0] a);
    case (a)
      25'h0100000: return 32'hBEEF_1234;
      25'h010000C: return 32'hCAFE_5678;
      25'h0100020: return 32'h1111_2222;
      25'h0100040: return 32'h3333_4444;
      25'h0100050: return 32'h5555_6666;
      25'h0100060: return 32'h7777_8888;
      default:     return 32'h0BAD_0BAD;
    endcase
  endfunction

  int          ram_lat  = 5;
  int          ram_cnt  = 0;
  logic        ram_busy = 1'b0;
  logic [24:0] ram_addr = 25'h0;

  always @(posedge clk_ram) begin
    if (ram_busy) begin
      if (ram_cnt >= ram_lat) begin
        sdram_dout   <= mem_word(ram_addr);
        sdram_rd_ack <= ~sdram_rd_ack;
        ram_busy     <= 1'b0;
        ack_cnt      <= ack_cnt + 1;
      end else begin
        ram_cnt <= ram_cnt + 1;
      end
    end else if (sdram_rd_req != sdram_rd_ack) begin
      ram_busy <= 1'b1;
      ram_addr <= sdram_raddr;
      ram_cnt  <= 1;
    end
  end

  // Data monitor: each falling rom_readyn pops one expectation.
  initial begin
    logic        prev = 1'b1;
    int          low  = 0;
    logic [15:0] e;
    forever begin
      @(negedge clk_cpu);
      if (mon_en) begin
        if (!rom_readyn) begin
          if (prev) begin
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("rom_do", 32'(rom_do), 32'(e));
            end else begin
              check("spurious_readyn", 32'(rom_readyn), 32'd1);
            end
          end
          low = low + 1;
        end else begin
          if (!prev) check("readyn_width", 32'(low), 32'd2);
          low = 0;
        end
      end
      prev = rom_readyn;
    end
  end

  // Request monitor: every toggle must find all earlier requests acked.
  initial begin
    logic prev_req = 1'b0;
    forever begin
      @(negedge clk_cpu);
      if (mon_en && (sdram_rd_req != prev_req)) begin
        check("req_after_ack", 32'(ack_cnt), 32'(tog_cnt));
        tog_cnt    = tog_cnt + 1;
        last_raddr = sdram_raddr;
      end
      prev_req = sdram_rd_req;
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!rom_readyn && n < 400) begin @(negedge clk_cpu); n++; end
    while (rom_readyn && n < 400) begin @(negedge clk_cpu); n++; end
    if (rom_readyn) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: readyn=1 after %0d cycles, required 0", name, n);
    end
  endtask

  task automatic do_read(input logic [19:0] a, input logic [15:0] d, input int inc,
                         input logic [24:0] ra, input string name);
    int t0;
    @(negedge clk_cpu);
    t0      = tog_cnt;
    rom_a   = a;
    rom_cen = 1'b0;
    exp_q.push_back(d);
    wait_ready(name);
    rom_cen = 1'b1;
    check({name, "_toggles"}, 32'(tog_cnt - t0), 32'(inc));
    if (inc != 0) check({name, "_raddr"}, 32'(last_raddr), 32'(ra));
  endtask

  logic [19:0] b2b_a[4] = '{20'h00020, 20'h00028, 20'h00029, 20'h00030};
  logic [15:0] b2b_d[4] = '{16'h4444, 16'h6666, 16'h5555, 16'h8888};

  initial begin
    int t0;
    int n;
    repeat (3) @(negedge clk_cpu);
    reset = 1'b0;
    check("rst_readyn", 32'(rom_readyn), 32'd1);
    check("rst_rom_do", 32'(rom_do), 32'd0);
    check("rst_raddr", 32'(sdram_raddr), 32'd0);
    mon_en = 1'b1;

    do_read(20'h00000, 16'h1234, 1, 25'h0100000, "cold_miss");
    do_read(20'h00001, 16'hBEEF, 0, 25'h0, "same_word_hit");
    do_read(20'h00006, 16'h5678, 1, 25'h010000C, "base_word");
    do_read(20'h00007, 16'hCAFE, 0, 25'h0, "pre_inval_hit");
    @(negedge clk_cpu); inval = 1'b1;
    @(negedge clk_cpu); inval = 1'b0;
    do_read(20'h00007, 16'hCAFE, 1, 25'h010000C, "post_inval");

    // Reset while WAIT holds an in-flight fetch.
    ram_lat = 10;
    @(negedge clk_cpu);
    t0      = tog_cnt;
    rom_a   = 20'h00010;
    rom_cen = 1'b0;
    n = 0;
    while (tog_cnt == t0 && n < 100) begin @(negedge clk_cpu); n++; end
    check("midrst_req_issued", 32'(tog_cnt - t0), 32'd1);
    @(negedge clk_cpu); reset = 1'b1; rom_cen = 1'b1;
    @(negedge clk_cpu); reset = 1'b0;
    check("midrst_readyn", 32'(rom_readyn), 32'd1);
    check("midrst_rom_do", 32'(rom_do), 32'd0);
    check("midrst_raddr", 32'(sdram_raddr), 32'd0);
    do_read(20'h00021, 16'h3333, 1, 25'h0100040, "midrst_new");
    ram_lat = 5;

    // Back-to-back: rom_cen held low across hit, miss, hit, miss.
    @(negedge clk_cpu);
    t0      = tog_cnt;
    rom_a   = b2b_a[0];
    rom_cen = 1'b0;
    exp_q.push_back(b2b_d[0]);
    for (int i = 0; i < 4; i++) begin
      wait_ready("b2b");
      if (i < 3) begin
        rom_a = b2b_a[i+1];
        exp_q.push_back(b2b_d[i+1]);
      end else begin
        rom_cen = 1'b1;
      end
    end
    check("b2b_toggles", 32'(tog_cnt - t0), 32'd2);

    repeat (30) @(negedge clk_cpu);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("total_toggles", 32'(tog_cnt), 32'd7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_fetch.md
# rom_fetch

CPU-side responder for the BIOS/ROM fetch path. Accepts 16-bit ROM read cycles from the machine (`rom_cen`, `rom_a`) and returns `rom_do` with `rom_readyn`. Satisfies them from a one-line, 32-bit fetch buffer, or from SDRAM through a toggle request/acknowledge handshake that crosses into the `clk_ram` domain. It is the read-side counterpart of the loader that writes ROM images into SDRAM with the same toggle protocol.

## Interface
Parameters:
- `ROM_BASE`, default 25'h0000000: SDRAM byte address of ROM halfword 0; must be 4-byte aligned.

Ports:
- `clk_cpu`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high; clock clk_cpu.
- `ce`, in, 1: CPU clock enable. CPU-facing state advances only when `ce`=1.
- `inval`, in, 1: level; clears the buffer valid bit while high (tied to ROM download active).
- `rom_cen`, in, 1: active-low ROM access request.
- `rom_a`, in, 20: halfword address.
- `rom_do`, out, 16: read data.
- `rom_readyn`, out, 1: active-low data-valid strobe.
- `sdram_raddr`, out, 25: SDRAM byte address of the requested 32-bit word.
- `sdram_rd_req`, out, 1: request toggle.
- `sdram_rd_ack`, in, 1: acknowledge toggle, asynchronous (`clk_ram` domain).
- `sdram_dout`, in, 32: read data; stable from the `ack` toggle until the next request.

## Operation
- Word address = `rom_a[19:1]`. `sdram_raddr` = `ROM_BASE + {rom_a[19:1], 2'b00}`, with 25-bit wrap.
- Halfword select: `rom_a[0]`=0 selects `sdram_dout[15:0]`; 1 selects `[31:16]`.
- Buffer holds `line[31:0]`, `tag[18:0]` and `valid`.
  - Hit = `valid` and `tag == rom_a[19:1]`.
  - `inval` clears `valid` on every `clk_cpu` edge while high and has priority over the fill at the same edge.
- `sdram_rd_ack` is passed through a 2-flop synchronizer to give `ack_s`. A request is outstanding while `req_tog != ack_s`.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, on a `ce` cycle with `rom_cen`=0:
    - Hit: drive `rom_do` from the line and go to DONE.
    - Miss, no request outstanding: latch the address, toggle `req_tog`, go to WAIT.
    - Miss, request outstanding: stay in IDLE; the access is retried on a later `ce` cycle.
  - WAIT, on any `clk_cpu` edge (ignores `ce`) where `ack_s == req_tog`:
    - Capture `sdram_dout` into the line and set `tag`.
    - Set `valid` unless `inval` is high.
    - Go to DONE.
  - DONE, on a `ce` cycle:
    - Drive `rom_readyn`=0 and `rom_do` from the line, using the latched `rom_a[0]`.
    - Return to IDLE.
- `rom_readyn` is low for exactly one `ce` cycle per access.
- If `rom_cen` stays low after a ready cycle, the next `ce` cycle starts a new access (back-to-back).
- `rom_cen` rising while in WAIT does not abort the fetch. The line is filled and DONE is still signalled, and the CPU ignores the strobe.
- Reset:
  - Outputs: `rom_readyn`=1, `rom_do`=0, `sdram_raddr`=0.
  - State: state=IDLE, `valid`=0.
  - `req_tog` and the synchronizer are NOT reset; they are initialised to 0 at configuration. A fetch in flight at reset therefore completes into nothing, and IDLE holds off a new request until `req_tog == ack_s`.

## Timing
- Hit: `rom_cen` sampled at `ce` cycle N gives `rom_readyn`=0 at `ce` cycle N+1.
- Miss:
  - `sdram_rd_req` toggles at the `clk_cpu` edge of `ce` cycle N.
  - Data arrives at SDRAM latency + 2 `clk_cpu` for the synchronizer + 1 for the capture, and is then presented at the next `ce` cycle.
- A second halfword of the same word is a hit: 1 `ce` cycle.
- `sdram_raddr` is held stable from the request toggle until the FSM leaves WAIT.
- All outputs are registered. No combinational path exists from `sdram_*` inputs to CPU outputs.

## Structure
- The FSM state enum and the `ROM_BASE` default go in the shared `pcfx_mem_pkg`.
- One sub-module, `sync2`: a 2-flop synchronizer, reused for `sdram_rd_ack`.
- The toggle protocol matches the loader's write side, so `sdram` needs no changes.

## Test plan
- Cold miss:
  - Stimulus: reset, then `rom_a`=20'h00000 with `cen`=0. The SDRAM model acks after 5 `clk_ram` and returns 32'hBEEF_1234.
  - Response: one toggle with `raddr`=25'h0, then `readyn`=0 with `rom_do`=16'h1234.
- Same-word hit:
  - Stimulus: immediately after the cold miss, `rom_a`=20'h00001.
  - Response: `rom_do`=16'hBEEF on the next `ce` cycle, with no new toggle.
- Different word with base:
  - Stimulus: `ROM_BASE`=25'h100000, `rom_a`=20'h00006.
  - Response: `raddr`=25'h10000C, and the toggle count increments by 1.
- Invalidate:
  - Stimulus: `inval` pulse after a hit-producing fill, then re-read the same address.
  - Response: a new toggle is issued and the data is refetched.
- Reset mid-fetch:
  - Stimulus: assert `reset` in WAIT, with the ack arriving 3 cycles later, then issue a new read.
  - Response: the second request toggles only after `ack_s` matches. The returned data comes from the new address, and there is no spurious `readyn`.
- Back-to-back:
  - Stimulus: `cen` held low over 4 addresses alternating hit and miss.
  - Response: exactly 4 single-cycle `readyn` pulses with the correct data.
